alu_seq: RTL and testbench



---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_mul_iter.sv | 54 +++++
 rtl/alu_seq.sv | 161 ++++++++++++++++
 tb/tb_alu_seq.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and FSM definitions for the sequential execute-stage ALU.
package alu_pkg;

  localparam logic [4:0] UOP_ADD = 5'b00001;
  localparam logic [4:0] UOP_SUB = 5'b00010;
  localparam logic [4:0] UOP_AND = 5'b00011;
  localparam logic [4:0] UOP_XOR = 5'b00100;
  localparam logic [4:0] UOP_CMP = 5'b00101;
  localparam logic [4:0] UOP_LSL = 5'b00110;
  localparam logic [4:0] UOP_LSR = 5'b00111;
  localparam logic [4:0] UOP_MOV = 5'b01000;
  localparam logic [4:0] UOP_ADC = 5'b01001;
  localparam logic [4:0] UOP_SBC = 5'b01010;
  localparam logic [4:0] UOP_ORR = 5'b01011;
  localparam logic [4:0] UOP_ASR = 5'b01100;
  localparam logic [4:0] UOP_TST = 5'b01101;
  localparam logic [4:0] UOP_MUL = 5'b01110;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  typedef enum logic {
    IDLE,
    MUL_BUSY
  } state_t;

  // Compare-style ops write flags regardless of set_flags.
  function automatic logic is_flag_always(input logic [4:0] uop);
    return (uop == UOP_CMP) || (uop == UOP_TST);
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Shift-add multiplier: one multiplier bit per cycle, low WIDTH bits of a*b.
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH);

  logic             run;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc_nxt;

  // The final iteration's partial sum is presented combinationally so the
  // product is ready on the cycle done is high.
  assign acc_nxt = acc + (mplier[0] ? mcand : '0);
  assign done    = run && (cnt == CNT_W'(WIDTH - 1));
  assign product = acc_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      run <= 1'b0;
      cnt <= '0;
    end else if (start) begin
      run <= 1'b1;
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + CNT_W'(1);
      if (done) run <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
    end else if (run) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked execute-stage ALU with registered result, NZCV flag register and iterative MUL.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] lhs,
  input  logic [WIDTH-1:0] rhs,
  input  logic [4:0]       uop,
  input  logic             set_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             result_we,
  output logic [3:0]       flags,
  output logic             busy
);

  state_t             state;
  logic               mul_sf;
  logic               accept;
  logic               mul_done;
  logic [WIDTH-1:0]   mul_product;
  logic [SHAMT_W-1:0] shamt;
  logic               add_cin;
  logic               sub_cin;
  logic [WIDTH:0]     sum_add;
  logic [WIDTH:0]     sum_sub;
  logic [WIDTH:0]     lsl_ext;
  logic [WIDTH:0]     lsr_ext;
  logic signed [WIDTH:0] asr_ext;
  logic [WIDTH-1:0]   res_p0;
  logic               we_p0;
  logic               upd_p0;
  logic               c_p0;
  logic               v_p0;
  logic [3:0]         flg_p0;

  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign shamt    = rhs[SHAMT_W-1:0];

  assign add_cin = (uop == UOP_ADC) ? flags[FLAG_C] : 1'b0;
  assign sub_cin = (uop == UOP_SBC) ? flags[FLAG_C] : 1'b1;
  assign sum_add = {1'b0, lhs} + {1'b0, rhs} + {{WIDTH{1'b0}}, add_cin};
  assign sum_sub = {1'b0, lhs} + {1'b0, ~rhs} + {{WIDTH{1'b0}}, sub_cin};
  // One guard bit beside the operand captures the last bit shifted out;
  // oversize amounts naturally fall out as 0 / all-sign with matching carry.
  assign lsl_ext = {1'b0, lhs} << shamt;
  assign lsr_ext = {lhs, 1'b0} >> shamt;
  assign asr_ext = $signed({lhs, 1'b0}) >>> shamt;

  // Stage p0: single-cycle compute from the offered operands and current flags.
  always_comb begin
    res_p0 = '0;
    we_p0  = 1'b1;
    upd_p0 = 1'b1;
    c_p0   = flags[FLAG_C];
    v_p0   = flags[FLAG_V];
    case (uop)
      UOP_ADD, UOP_ADC: begin
        res_p0 = sum_add[WIDTH-1:0];
        c_p0   = sum_add[WIDTH];
        v_p0   = ~(lhs[WIDTH-1] ^ rhs[WIDTH-1]) & (res_p0[WIDTH-1] ^ lhs[WIDTH-1]);
      end
      UOP_SUB, UOP_SBC, UOP_CMP: begin
        res_p0 = sum_sub[WIDTH-1:0];
        c_p0   = sum_sub[WIDTH];
        v_p0   = (lhs[WIDTH-1] ^ rhs[WIDTH-1]) & (res_p0[WIDTH-1] ^ lhs[WIDTH-1]);
      end
      UOP_AND, UOP_TST: res_p0 = lhs & rhs;
      UOP_XOR:          res_p0 = lhs ^ rhs;
      UOP_ORR:          res_p0 = lhs | rhs;
      UOP_MOV:          res_p0 = rhs;
      UOP_LSL: begin
        res_p0 = lsl_ext[WIDTH-1:0];
        if (shamt != '0) c_p0 = lsl_ext[WIDTH];
      end
      UOP_LSR: begin
        res_p0 = lsr_ext[WIDTH:1];
        if (shamt != '0) c_p0 = lsr_ext[0];
      end
      UOP_ASR: begin
        res_p0 = asr_ext[WIDTH:1];
        if (shamt != '0) c_p0 = asr_ext[0];
      end
      default: begin
        we_p0  = 1'b0;
        upd_p0 = 1'b0;
      end
    endcase
    if (is_flag_always(uop)) we_p0 = 1'b0;
    if (!set_flags && !is_flag_always(uop)) upd_p0 = 1'b0;
    flg_p0         = '0;
    flg_p0[FLAG_Z] = (res_p0 == '0);
    flg_p0[FLAG_C] = c_p0;
    flg_p0[FLAG_N] = res_p0[WIDTH-1];
    flg_p0[FLAG_V] = v_p0;
  end

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (accept && (uop == UOP_MUL)),
    .a       (lhs),
    .b       (rhs),
    .done    (mul_done),
    .product (mul_product)
  );

  // Stage p1: result/flag register and control FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      mul_sf    <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      result_we <= 1'b0;
      flags     <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (uop == UOP_MUL) begin
              state  <= MUL_BUSY;
              busy   <= 1'b1;
              mul_sf <= set_flags;
            end else begin
              result    <= res_p0;
              result_we <= we_p0;
              out_valid <= 1'b1;
              if (upd_p0) flags <= flg_p0;
            end
          end
        end
        MUL_BUSY: begin
          if (mul_done) begin
            state     <= IDLE;
            busy      <= 1'b0;
            result    <= mul_product;
            result_we <= 1'b1;
            out_valid <= 1'b1;
            if (mul_sf) begin
              flags[FLAG_N] <= mul_product[WIDTH-1];
              flags[FLAG_Z] <= (mul_product == '0);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed cases plus randomised traffic with backpressure.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] res;
    logic         we;
    logic [3:0]   fl;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] lhs;
  logic [W-1:0] rhs;
  logic [4:0]   uop;
  logic         set_flags;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         result_we;
  logic [3:0]   flags;
  logic         busy;

  exp_t       sb_q[$];
  logic [3:0] mflags;
  int         total = 0;
  int         bad = 0;
  bit         rand_rdy = 1'b0;

  alu_seq #(.WIDTH(W), .SHAMT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .lhs       (lhs),
    .rhs       (rhs),
    .uop       (uop),
    .set_flags (set_flags),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_we (result_we),
    .flags     (flags),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Reference model: flags in {V,N,C,Z} order, arithmetic checked via wide signed sums.
  function automatic exp_t model(input logic [4:0] op, input logic [W-1:0] l, input logic [W-1:0] r,
                                 input logic sf);
    exp_t        e;
    logic [W-1:0] res;
    logic        c;
    logic        v;
    logic        cin;
    logic        known;
    logic [W:0]  t;
    longint      s;
    int          sh;
    res   = '0;
    c     = mflags[1];
    v     = mflags[3];
    known = 1'b1;
    sh    = int'(r[7:0]);
    case (op)
      UOP_ADD, UOP_ADC: begin
        cin = (op == UOP_ADC) ? mflags[1] : 1'b0;
        t   = {1'b0, l} + {1'b0, r} + (W+1)'(cin);
        res = t[W-1:0];
        c   = t[W];
        s   = longint'($signed(l)) + longint'($signed(r)) + longint'(cin);
        v   = (s != longint'($signed(res)));
      end
      UOP_SUB, UOP_CMP, UOP_SBC: begin
        cin = (op == UOP_SBC) ? mflags[1] : 1'b1;
        t   = {1'b0, l} + {1'b0, ~r} + (W+1)'(cin);
        res = t[W-1:0];
        c   = t[W];
        s   = longint'($signed(l)) - longint'($signed(r)) - 64'sd1 + longint'(cin);
        v   = (s != longint'($signed(res)));
      end
      UOP_AND, UOP_TST: res = l & r;
      UOP_XOR: res = l ^ r;
      UOP_ORR: res = l | r;
      UOP_MOV: res = r;
      UOP_LSL: begin
        res = l;
        for (int i = 0; i < sh; i++) begin c = res[W-1]; res = res << 1; end
      end
      UOP_LSR: begin
        res = l;
        for (int i = 0; i < sh; i++) begin c = res[0]; res = res >> 1; end
      end
      UOP_ASR: begin
        res = l;
        for (int i = 0; i < sh; i++) begin c = res[0]; res = {res[W-1], res[W-1:1]}; end
      end
      UOP_MUL: res = l * r;
      default: known = 1'b0;
    endcase
    if (known && (sf || op == UOP_CMP || op == UOP_TST))
      mflags = {v, res[W-1], c, (res == '0)};
    e.res = res;
    e.we  = known && (op != UOP_CMP) && (op != UOP_TST);
    e.fl  = mflags;
    return e;
  endfunction

  // Offer one op; dir=1 pushes the given constants instead of the model's prediction.
  task automatic send(input logic [4:0] op, input logic [W-1:0] l, input logic [W-1:0] r,
                      input logic sf, input bit dir, input logic [W-1:0] xres,
                      input logic xwe, input logic [3:0] xfl);
    exp_t e;
    int   n;
    bit   got;
    in_valid  = 1'b1;
    uop       = op;
    lhs       = l;
    rhs       = r;
    set_flags = sf;
    n   = 0;
    got = 1'b0;
    while (!got && n < 300) begin
      @(negedge clk);
      n++;
      if (in_ready) got = 1'b1;
    end
    if (!got) begin
      check_val("accept_timeout", 0, 1);
    end else begin
      if (dir) begin
        e.res  = xres;
        e.we   = xwe;
        e.fl   = xfl;
        mflags = xfl;
      end else begin
        e = model(op, l, r, sf);
      end
      sb_q.push_back(e);
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_val("drain", sb_q.size(), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check_val("unexpected_out", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check_val("res", result, e.res);
        check_val("we", result_we, e.we);
        check_val("flg", flags, e.fl);
      end
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int busyc;
    int irc;
    int ovc;
    bit seen;
    logic [4:0] rop;
    logic [W-1:0] rr;
    rst = 1'b1; in_valid = 1'b0; lhs = '0; rhs = '0; uop = '0; set_flags = 1'b0;
    out_ready = 1'b1;
    mflags = 4'b0000;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_result", result, 0);
    check_val("rst_we", result_we, 0);
    check_val("rst_flags", flags, 0);
    check_val("rst_busy", busy, 0);
    @(posedge clk);
    #1;

    send(UOP_ADD, 32'h7FFF_FFFF, 32'h1, 1'b1, 1'b1, 32'h8000_0000, 1'b1, 4'b1100);
    @(negedge clk);
    check_val("add_latency1", out_valid, 1);
    @(posedge clk);
    #1;
    send(UOP_SUB, 32'd5, 32'd5, 1'b1, 1'b1, 32'h0, 1'b1, 4'b0011);
    send(UOP_CMP, 32'd3, 32'd5, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 4'b0100);
    send(UOP_ADD, 32'hFFFF_FFFF, 32'h1, 1'b1, 1'b1, 32'h0, 1'b1, 4'b0011);
    send(UOP_ADC, 32'h0, 32'h0, 1'b1, 1'b1, 32'h1, 1'b1, 4'b0000);
    send(UOP_LSL, 32'h8000_0001, 32'd1, 1'b1, 1'b1, 32'h2, 1'b1, 4'b0010);
    send(UOP_LSR, 32'hFFFF_FFFF, 32'd40, 1'b1, 1'b1, 32'h0, 1'b1, 4'b0001);
    send(UOP_ASR, 32'h8000_0000, 32'd40, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 4'b0110);

    send(UOP_MUL, 32'h0001_0000, 32'h0001_0000, 1'b1, 1'b1, 32'h0, 1'b1, 4'b0011);
    n = 0; busyc = 0; irc = 0; seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      if (out_valid) seen = 1'b1;
      else begin
        if (busy) busyc++;
        if (!in_ready) irc++;
      end
    end
    check_val("mul_out_cycle", n, 33);
    check_val("mul_busy_cycles", busyc, 32);
    check_val("mul_stall_cycles", irc, 32);
    @(posedge clk);
    #1;
    send(5'b11111, 32'h1234, 32'h5678, 1'b1, 1'b1, 32'h0, 1'b0, 4'b0011);
    drain();

    @(posedge clk);
    #1 out_ready = 1'b0;
    send(UOP_ADD, 32'h10, 32'h20, 1'b0, 1'b0, '0, 1'b0, 4'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("bp_valid", out_valid, 1);
      check_val("bp_in_ready", in_ready, 0);
      check_val("bp_result", result, sb_q[0].res);
      check_val("bp_flags", flags, sb_q[0].fl);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    @(posedge clk);
    #1 rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rop = 5'($urandom_range(0, 15));
      rr  = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 40)) : W'($urandom);
      send(rop, W'($urandom), rr, 1'($urandom_range(0, 1)), 1'b0, '0, 1'b0, 4'b0);
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    drain();

    @(posedge clk);
    #1;
    send(UOP_MUL, 32'd3, 32'd4, 1'b1, 1'b0, '0, 1'b0, 4'b0);
    void'(sb_q.pop_back());
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    mflags = 4'b0000;
    @(negedge clk);
    check_val("rstmul_out_valid", out_valid, 0);
    check_val("rstmul_flags", flags, 0);
    check_val("rstmul_in_ready", in_ready, 1);
    check_val("rstmul_busy", busy, 0);
    ovc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) ovc++;
    end
    check_val("rstmul_no_output", ovc, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
